pac_input_ctrl: RTL

Upstream control stage for the 8x8 Pac-Man matrix display. Turns four raw direction keys into the registered 2-bit heading `dir` and the mouth-animation bit `state` that the display stage consumes. It synchronises and debounces the keys, resolves simultaneous presses by fixed priority, and runs the mouth open/close timer.

---
 rtl/pac_input_ctrl_pkg.sv | 30 +++
 rtl/pac_input_ctrl_if.sv | 13 +
 rtl/pac_input_ctrl_key_debounce.sv | 49 ++++
 rtl/pac_input_ctrl.sv | 73 +++++++
 4 files changed

// File: rtl/pac_input_ctrl_pkg.sv
// Shared codes for the Pac-Man input/display path: heading and mouth encodings
// plus the fixed-priority press encoder.
package pac_input_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic {
        MOUTH_OPEN   = 1'b0,
        MOUTH_CLOSED = 1'b1
    } mouth_e;

    localparam int NUM_KEYS = 4;

    // Lowest set index wins: up > right > left > down.
    function automatic dir_e first_press(input logic [NUM_KEYS-1:0] press);
        // NOTE: the result gets a default before any branch, so every path
        // assigns it and no storage is implied in combinational use.
        first_press = DIR_UP;
        if (press[0])      first_press = DIR_UP;
        else if (press[1]) first_press = DIR_RIGHT;
        else if (press[2]) first_press = DIR_LEFT;
        else if (press[3]) first_press = DIR_DOWN;
    endfunction

endpackage

// File: rtl/pac_input_ctrl_if.sv
// Key/animation inputs and heading/mouth outputs of the input control stage.
interface pac_input_ctrl_if;
    import pac_input_ctrl_pkg::*;

    logic [NUM_KEYS-1:0] key;
    logic                anim_en;
    dir_e                dir;
    mouth_e              state;
    logic                dir_changed;

    modport master (output key, anim_en, input dir, state, dir_changed);
    modport slave  (input key, anim_en, output dir, state, dir_changed);
endinterface

// File: rtl/pac_input_ctrl_key_debounce.sv
// One raw key: 2-flop synchroniser followed by a stable-count debounce filter
// that exists only when PAC_DEBOUNCE_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic deb
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0] sync;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], key};
    end

`ifdef PAC_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync[1] == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= ~deb;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign deb = sync[1];
`endif

endmodule

// File: rtl/pac_input_ctrl.sv
// Pac-Man input control: debounced keys -> press edges -> priority heading,
// plus the mouth open/close timer. Debounce is enabled by PAC_DEBOUNCE_EN.
module pac_input_ctrl
    import pac_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int MOUTH_PERIOD    = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    pac_input_ctrl_if.slave   bus
);

    if (MOUTH_PERIOD < 2) begin : g_bad_cfg
        $error("pac_input_ctrl: MOUTH_PERIOD must be at least 2");
    end

    localparam int MW = $clog2(MOUTH_PERIOD);
    localparam logic [MW-1:0] MCNT_LAST = MW'(MOUTH_PERIOD - 1);

    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] deb_q;
    logic [NUM_KEYS-1:0] press;
    dir_e                next_dir;
    logic [MW-1:0]       mcnt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .key   (bus.key[i]),
            .deb   (deb[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb;
    end

    // Rising edges only: a held key never re-asserts, so a later press wins.
    assign press    = deb & ~deb_q;
    assign next_dir = first_press(press);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dir         <= DIR_RIGHT;
            bus.dir_changed <= 1'b0;
        end else begin
            bus.dir_changed <= 1'b0;
            if (|press) begin
                bus.dir         <= next_dir;
                bus.dir_changed <= (next_dir != bus.dir);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt      <= '0;
            bus.state <= MOUTH_OPEN;
        end else if (!bus.anim_en) begin
            mcnt      <= '0;
            bus.state <= MOUTH_OPEN;
        end else if (mcnt == MCNT_LAST) begin
            mcnt      <= '0;
            bus.state <= (bus.state == MOUTH_OPEN) ? MOUTH_CLOSED : MOUTH_OPEN;
        end else begin
            mcnt <= mcnt + 1'b1;
        end
    end

endmodule
